// File: rtl/wdrr_pkg.sv
// Shared types and default widths for the WDRR scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wdrr_pkg;

  localparam int AXI_DATA_WIDTH_DEF = 32;
  localparam int QUEUES_NUM_DEF     = 64;
  localparam int QUEUES_NUM_BIT_DEF = 6;
  localparam int LEN_WIDTH_DEF      = 16;
  localparam int DEFICIT_WIDTH_DEF  = 20;

  // Scheduler walk: examine a queue, try its head packet, wait for dequeue.
  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_SERVE = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  // Deficit plus quantum, clamped to the all-ones deficit value.
  function automatic logic [DEFICIT_WIDTH_DEF-1:0] deficit_sat_add(
    input logic [DEFICIT_WIDTH_DEF-1:0] deficit,
    input logic [DEFICIT_WIDTH_DEF-1:0] quantum
  );
    logic [DEFICIT_WIDTH_DEF:0] sum;
    sum = {1'b0, deficit} + {1'b0, quantum};
    return sum[DEFICIT_WIDTH_DEF] ? {DEFICIT_WIDTH_DEF{1'b1}} : sum[DEFICIT_WIDTH_DEF-1:0];
  endfunction

endpackage

// File: rtl/wdrr_stat_counters.sv
// Per-queue packet and byte counters, flattened onto the register read-back bus.
// Latency: an increment or clear is visible on stat_regs the cycle after it is applied.
// Backpressure: none; clear wins over a coincident increment, which is dropped.
module wdrr_stat_counters
  import wdrr_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
  parameter int QUEUES_NUM     = QUEUES_NUM_DEF,
  parameter int QUEUES_NUM_BIT = QUEUES_NUM_BIT_DEF,
  parameter int LEN_WIDTH      = LEN_WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  inc_en,
  input  logic [QUEUES_NUM_BIT-1:0]             inc_queue,
  input  logic [LEN_WIDTH-1:0]                  inc_len,
  output logic [QUEUES_NUM*2*AXI_DATA_WIDTH-1:0] stat_regs
);

  logic [AXI_DATA_WIDTH-1:0] pkt_cnt  [QUEUES_NUM];
  logic [AXI_DATA_WIDTH-1:0] byte_cnt [QUEUES_NUM];

  // Counters wrap naturally; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUES_NUM; i++) begin
        pkt_cnt[i]  <= '0;
        byte_cnt[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < QUEUES_NUM; i++) begin
        pkt_cnt[i]  <= '0;
        byte_cnt[i] <= '0;
      end
    end else if (inc_en) begin
      pkt_cnt[inc_queue]  <= pkt_cnt[inc_queue] + AXI_DATA_WIDTH'(1);
      byte_cnt[inc_queue] <= byte_cnt[inc_queue]
                             + {{(AXI_DATA_WIDTH-LEN_WIDTH){1'b0}}, inc_len};
    end
  end

  // Packet counts occupy the low half of the bus, byte counts the high half.
  always_comb begin
    stat_regs = '0;
    for (int i = 0; i < QUEUES_NUM; i++) begin
      stat_regs[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]                = pkt_cnt[i];
      stat_regs[(QUEUES_NUM+i)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]   = byte_cnt[i];
    end
  end

endmodule

// File: rtl/wdrr_scheduler.sv
// Weighted deficit round-robin picker issuing one dequeue grant at a time.
// Latency: non-empty queue seen in SCAN -> grant_valid two cycles later; grants >= 2 cycles apart.
// Backpressure: grant held stable while grant_ready is low; scheduler stalls in GRANT.
module wdrr_scheduler
  import wdrr_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
  parameter int QUEUES_NUM     = QUEUES_NUM_DEF,
  parameter int QUEUES_NUM_BIT = QUEUES_NUM_BIT_DEF,
  parameter int LEN_WIDTH      = LEN_WIDTH_DEF,
  parameter int DEFICIT_WIDTH  = DEFICIT_WIDTH_DEF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cfg_enable,
  input  logic [QUEUES_NUM*AXI_DATA_WIDTH-1:0]   cfg_quantum,
  input  logic                                   stats_clear,
  input  logic [QUEUES_NUM-1:0]                  q_nonempty,
  input  logic [QUEUES_NUM*LEN_WIDTH-1:0]        q_head_len,
  output logic                                   grant_valid,
  output logic [QUEUES_NUM_BIT-1:0]              grant_queue,
  output logic [LEN_WIDTH-1:0]                   grant_len,
  input  logic                                   grant_ready,
  output logic [QUEUES_NUM*2*AXI_DATA_WIDTH-1:0] stat_regs
);

  localparam logic [QUEUES_NUM_BIT-1:0] LAST_Q = QUEUES_NUM_BIT'(QUEUES_NUM - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [QUEUES_NUM_BIT-1:0] ptr;
  logic [DEFICIT_WIDTH-1:0]  deficit [QUEUES_NUM];

  logic                      cur_ne;
  logic [LEN_WIDTH-1:0]      cur_len;
  logic [DEFICIT_WIDTH-1:0]  cur_quantum;
  logic [DEFICIT_WIDTH-1:0]  cur_deficit;
  logic [DEFICIT_WIDTH:0]    quantum_sum;
  logic [DEFICIT_WIDTH-1:0]  deficit_topped;
  logic                      head_fits;

  logic                      do_add;
  logic                      do_zero;
  logic                      do_adv;
  logic                      do_load;
  logic                      do_take;

  // Only the low deficit-width bits of each quantum word matter.
  logic                      unused_quantum_bits;
  assign unused_quantum_bits = ^cfg_quantum;

  // Views of the queue currently under the pointer.
  always_comb begin
    cur_ne         = q_nonempty[ptr];
    cur_len        = q_head_len[int'(ptr)*LEN_WIDTH +: LEN_WIDTH];
    cur_quantum    = cfg_quantum[int'(ptr)*AXI_DATA_WIDTH +: DEFICIT_WIDTH];
    cur_deficit    = deficit[ptr];
    quantum_sum    = {1'b0, cur_deficit} + {1'b0, cur_quantum};
    deficit_topped = quantum_sum[DEFICIT_WIDTH] ? {DEFICIT_WIDTH{1'b1}}
                                                : quantum_sum[DEFICIT_WIDTH-1:0];
    head_fits      = ({{(DEFICIT_WIDTH-LEN_WIDTH){1'b0}}, cur_len} <= cur_deficit);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_SCAN;
    else       state <= state_nxt;
  end

  // Next state; a disabled scheduler parks in SCAN once any grant completes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SCAN: begin
        if (cfg_enable && cur_ne) state_nxt = ST_SERVE;
      end
      ST_SERVE: begin
        if (cfg_enable && cur_ne && head_fits) state_nxt = ST_GRANT;
        else                                   state_nxt = ST_SCAN;
      end
      ST_GRANT: begin
        if (grant_ready) state_nxt = ST_SERVE;
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    do_add  = 1'b0;
    do_zero = 1'b0;
    do_adv  = 1'b0;
    do_load = 1'b0;
    do_take = 1'b0;
    case (state)
      ST_SCAN: begin
        if (cfg_enable) begin
          do_add  = cur_ne;
          do_zero = !cur_ne;
          do_adv  = !cur_ne;
        end
      end
      ST_SERVE: begin
        if (cfg_enable) begin
          do_zero = !cur_ne;
          do_adv  = !cur_ne || !head_fits;
          do_load = cur_ne && head_fits;
        end
      end
      ST_GRANT: begin
        do_take = grant_ready;
      end
      default: ;
    endcase
  end

  // Round-robin pointer, one queue per step, wrapping at the last queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ptr <= '0;
    else if (do_adv) ptr <= (ptr == LAST_Q) ? '0 : ptr + 1'b1;
  end

  // Deficit bookkeeping: top up on visit, forget when empty, charge on dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUES_NUM; i++) deficit[i] <= '0;
    end else if (do_add) begin
      deficit[ptr] <= deficit_topped;
    end else if (do_zero) begin
      deficit[ptr] <= '0;
    end else if (do_take) begin
      deficit[ptr] <= cur_deficit - {{(DEFICIT_WIDTH-LEN_WIDTH){1'b0}}, grant_len};
    end
  end

  // Grant register, loaded once in SERVE and frozen until the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_valid <= 1'b0;
      grant_queue <= '0;
      grant_len   <= '0;
    end else if (do_load) begin
      grant_valid <= 1'b1;
      grant_queue <= ptr;
      grant_len   <= cur_len;
    end else if (do_take) begin
      grant_valid <= 1'b0;
    end
  end

  wdrr_stat_counters #(
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .QUEUES_NUM     (QUEUES_NUM),
    .QUEUES_NUM_BIT (QUEUES_NUM_BIT),
    .LEN_WIDTH      (LEN_WIDTH)
  ) u_stats (
    .clk       (clk),
    .reset     (reset),
    .clear     (stats_clear),
    .inc_en    (do_take),
    .inc_queue (grant_queue),
    .inc_len   (grant_len),
    .stat_regs (stat_regs)
  );

endmodule
